// File: rtl/video_timing_gen_pkg.sv
// Shared raster constants and coordinate type.
// Default 640x480 timing plus derived start/total values.
package video_timing_gen_pkg;

  localparam int CORDW  = 12;

  localparam int HRES   = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int VRES   = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_STA  = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA  = -(V_FP + V_SYNC + V_BP);
  localparam int H_TOT  = HRES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = VRES + V_FP + V_SYNC + V_BP;

  typedef logic signed [CORDW-1:0] coord_t;

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing: signed hpos/vpos, syncs, de, line/frame strobes.
// Ports: pixel_clk, rst_n in; hpos,vpos,hsync,vsync,de,lsync,fsync,frame_cnt out.
module video_timing_gen #(
  parameter int   H_RES  = video_timing_gen_pkg::HRES,
  parameter int   H_FP   = video_timing_gen_pkg::H_FP,
  parameter int   H_SYNC = video_timing_gen_pkg::H_SYNC,
  parameter int   H_BP   = video_timing_gen_pkg::H_BP,
  parameter int   V_RES  = video_timing_gen_pkg::VRES,
  parameter int   V_FP   = video_timing_gen_pkg::V_FP,
  parameter int   V_SYNC = video_timing_gen_pkg::V_SYNC,
  parameter int   V_BP   = video_timing_gen_pkg::V_BP,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0
) (
  input  logic                                       pixel_clk,
  input  logic                                       rst_n,
  output logic signed [video_timing_gen_pkg::CORDW-1:0] hpos,
  output logic signed [video_timing_gen_pkg::CORDW-1:0] vpos,
  output logic                                       hsync,
  output logic                                       vsync,
  output logic                                       de,
  output logic                                       lsync,
  output logic                                       fsync,
  output logic [15:0]                                frame_cnt
);
  import video_timing_gen_pkg::*;

  localparam coord_t H_START = coord_t'(-(H_FP + H_SYNC + H_BP));
  localparam coord_t V_START = coord_t'(-(V_FP + V_SYNC + V_BP));
  localparam coord_t H_LAST  = coord_t'(H_RES - 1);
  localparam coord_t V_LAST  = coord_t'(V_RES - 1);
  localparam coord_t HS_BEG  = coord_t'(-(H_SYNC + H_BP));
  localparam coord_t HS_END  = coord_t'(-H_BP - 1);
  localparam coord_t VS_BEG  = coord_t'(-(V_SYNC + V_BP));
  localparam coord_t VS_END  = coord_t'(-V_BP - 1);

  if (H_RES + H_FP + H_SYNC + H_BP > 2047) begin : g_hchk
    $error("horizontal total exceeds signed coordinate range");
  end
  if (V_RES + V_FP + V_SYNC + V_BP > 2047) begin : g_vchk
    $error("vertical total exceeds signed coordinate range");
  end

  coord_t h_nxt;
  coord_t v_nxt;
  logic   wrap_f;

  always_comb begin
    h_nxt  = hpos + coord_t'(1);
    v_nxt  = vpos;
    wrap_f = 1'b0;
    if (hpos == H_LAST) begin
      h_nxt = H_START;
      if (vpos == V_LAST) begin
        v_nxt  = V_START;
        wrap_f = 1'b1;
      end else begin
        v_nxt = vpos + coord_t'(1);
      end
    end
  end

  // Flags decode the next-state counters so they line up
  // with the coordinates registered on the same edge.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos      <= H_START;
      vpos      <= V_START;
      hsync     <= ~H_POL;
      vsync     <= ~V_POL;
      de        <= 1'b0;
      lsync     <= 1'b0;
      fsync     <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      hpos      <= h_nxt;
      vpos      <= v_nxt;
      hsync     <= (h_nxt >= HS_BEG && h_nxt <= HS_END)
                   ? H_POL : ~H_POL;
      vsync     <= (v_nxt >= VS_BEG && v_nxt <= VS_END)
                   ? V_POL : ~V_POL;
      de        <= !h_nxt[CORDW-1] && !v_nxt[CORDW-1];
      lsync     <= (h_nxt == H_START);
      fsync     <= wrap_f;
      frame_cnt <= frame_cnt + {15'd0, wrap_f};
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: random reset drops, cycle-count reference model.
// Three instances: small active-low, small active-high, default timing.
module tb_video_timing_gen;
  import video_timing_gen_pkg::*;

  localparam int A_HR = 20, A_HF = 3, A_HS = 4, A_HB = 5;
  localparam int A_VR = 6,  A_VF = 2, A_VS = 2, A_VB = 3;
  localparam int A_FT = (A_HR+A_HF+A_HS+A_HB) * (A_VR+A_VF+A_VS+A_VB);

  typedef struct {
    logic [44:0] a;
    logic [44:0] b;
    logic [44:0] d;
  } exp_t;

  logic clk;
  logic rst_n;

  logic signed [11:0] hp_a, vp_a, hp_b, vp_b, hp_d, vp_d;
  logic hs_a, vs_a, de_a, ls_a, fs_a;
  logic hs_b, vs_b, de_b, ls_b, fs_b;
  logic hs_d, vs_d, de_d, ls_d, fs_d;
  logic [15:0] fc_a, fc_b, fc_d;

  video_timing_gen #(
    .H_RES(A_HR), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_RES(A_VR), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_a (
    .pixel_clk(clk), .rst_n(rst_n), .hpos(hp_a), .vpos(vp_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .lsync(ls_a),
    .fsync(fs_a), .frame_cnt(fc_a)
  );

  video_timing_gen #(
    .H_RES(A_HR), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_RES(A_VR), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_b (
    .pixel_clk(clk), .rst_n(rst_n), .hpos(hp_b), .vpos(vp_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .lsync(ls_b),
    .fsync(fs_b), .frame_cnt(fc_b)
  );

  video_timing_gen u_d (
    .pixel_clk(clk), .rst_n(rst_n), .hpos(hp_d), .vpos(vp_d),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .lsync(ls_d),
    .fsync(fs_d), .frame_cnt(fc_d)
  );

  logic [44:0] act_a, act_b, act_d;
  assign act_a = {hp_a, vp_a, hs_a, vs_a, de_a, ls_a, fs_a, fc_a};
  assign act_b = {hp_b, vp_b, hs_b, vs_b, de_b, ls_b, fs_b, fc_b};
  assign act_d = {hp_d, vp_d, hs_d, vs_d, de_d, ls_d, fs_d, fc_d};

  // Expected outputs after k rising edges with reset released.
  // The raster is a flat sequence of H_TOT*V_TOT positions, each
  // line/frame starting with front porch, then sync, back porch, active.
  function automatic logic [44:0] model(
    input int hr, input int hf, input int hs, input int hb,
    input int vr, input int vf, input int vs, input int vb,
    input bit hpol, input bit vpol, input int k
  );
    int htot, vtot, ft, n, col, row, h, v, fc;
    bit hact, vact, de_e, ls_e, fs_e;
    logic [11:0] h12, v12;
    htot = hr + hf + hs + hb;
    vtot = vr + vf + vs + vb;
    ft   = htot * vtot;
    n    = k % ft;
    col  = n % htot;
    row  = n / htot;
    h    = col - (hf + hs + hb);
    v    = row - (vf + vs + vb);
    hact = (col >= hf) && (col < hf + hs);
    vact = (row >= vf) && (row < vf + vs);
    de_e = (h >= 0) && (v >= 0);
    ls_e = (k > 0) && (col == 0);
    fs_e = (k > 0) && (n == 0);
    fc   = (k / ft) % 65536;
    h12  = 12'(h);
    v12  = 12'(v);
    return {h12, v12, hact ? hpol : ~hpol, vact ? vpol : ~vpol,
            de_e, ls_e, fs_e, 16'(fc)};
  endfunction

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  int   cyc = 0;

  task automatic cmp(input string nm, input logic [44:0] act,
                     input logic [44:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d k=%0d got=%h exp=%h",
               nm, cyc, k, act, exp);
    end
  endtask

  task automatic step(input bit r);
    exp_t e;
    @(posedge clk);
    if (rst_n) k++;
    #1;
    rst_n = r;
    if (!r) k = 0;
    cyc++;
    e.a = model(A_HR, A_HF, A_HS, A_HB, A_VR, A_VF, A_VS, A_VB,
                1'b0, 1'b0, k);
    e.b = model(A_HR, A_HF, A_HS, A_HB, A_VR, A_VF, A_VS, A_VB,
                1'b1, 1'b1, k);
    e.d = model(HRES, H_FP, H_SYNC, H_BP, VRES, V_FP, V_SYNC, V_BP,
                1'b0, 1'b0, k);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("inst_neg_pol", act_a, e.a);
      cmp("inst_pos_pol", act_b, e.b);
      cmp("inst_default", act_d, e.d);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0);
    for (int i = 0; i < 2 * A_FT + 850; i++) step(1'b1);
    for (int j = 0; j < 20; j++) begin
      int run = $urandom_range(1, 700);
      int hold = $urandom_range(1, 4);
      for (int i = 0; i < run; i++) step(1'b1);
      for (int i = 0; i < hold; i++) step(1'b0);
    end
    for (int i = 0; i < 3 * A_FT + 5; i++) step(1'b1);
    @(negedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
